// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl -- fetch/execute sequencer for the Hack-style CPU program counter.
//
// Fetches one instruction per pass over a req/ack handshake, holds it in the
// instruction register, decodes C-instruction jump bits against the ALU flags
// during a single EXEC cycle and issues exactly one PC strobe per instruction.
// Supports free-run, single-step and a sticky fetch-timeout error.
//
// Ports:
//   clk50m, rst_n        clock (rising edge), async active-low reset
//   run, step            free-run level / single-instruction pulse
//   instr_req/ack/in     instruction memory handshake and data
//   ir                   instruction register to datapath decode
//   exec_valid           datapath write-commit strobe (EXEC cycle)
//   alu_zr, alu_ng       ALU flags, valid during EXEC
//   a_reg                jump target
//   pc_en/load/inc       program counter controls, pc_cnt_in = a_reg
//   halted, fetch_err    status
module pc_seq_ctrl #(
    parameter int W   = 15,
    parameter int IW  = 16,
    parameter int TMO = 64
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic          run,
    input  logic          step,
    output logic          instr_req,
    input  logic          instr_ack,
    input  logic [IW-1:0] instr_in,
    output logic [IW-1:0] ir,
    output logic          exec_valid,
    input  logic          alu_zr,
    input  logic          alu_ng,
    input  logic [W-1:0]  a_reg,
    output logic          pc_en,
    output logic          pc_load,
    output logic          pc_inc,
    output logic [W-1:0]  pc_cnt_in,
    output logic          halted,
    output logic          fetch_err
);

    localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {S_HALT, S_FETCH, S_WAIT, S_EXEC} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          single, single_nx;
    logic          err_nx;
    logic          ld_ir;
    logic          taken;

    assign pc_cnt_in = a_reg;

    // A-instructions (MSB clear) never jump.
    assign taken = ir[IW-1] & ((ir[2] & alu_ng) | (ir[1] & alu_zr) |
                               (ir[0] & ~alu_zr & ~alu_ng));

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HALT;
            ir        <= '0;
            fetch_err <= 1'b0;
            single    <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            fetch_err <= err_nx;
            single    <= single_nx;
            cnt       <= cnt_nx;
            if (ld_ir) ir <= instr_in;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        single_nx  = single;
        err_nx     = fetch_err;
        ld_ir      = 1'b0;
        instr_req  = 1'b0;
        exec_valid = 1'b0;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        halted     = 1'b0;
        case (state)
            S_HALT: begin
                halted = 1'b1;
                if (run || step) begin
                    state_nx  = S_FETCH;
                    err_nx    = 1'b0;
                    // run wins over step: both high means free-run
                    single_nx = step & ~run;
                end
            end
            S_FETCH: begin
                instr_req = 1'b1;
                cnt_nx    = '0;
                if (instr_ack) begin
                    ld_ir    = 1'b1;
                    state_nx = S_EXEC;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                instr_req = 1'b1;
                if (instr_ack) begin
                    ld_ir    = 1'b1;
                    state_nx = S_EXEC;
                    cnt_nx   = '0;
                end else if (cnt == CW'(TMO - 1)) begin
                    // TMO WAIT cycles without ack: give up, keep old ir
                    err_nx    = 1'b1;
                    single_nx = 1'b0;
                    cnt_nx    = '0;
                    state_nx  = S_HALT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_EXEC: begin
                exec_valid = 1'b1;
                pc_en      = 1'b1;
                pc_load    = taken;
                pc_inc     = ~taken;
                if (single || !run) begin
                    state_nx  = S_HALT;
                    single_nx = 1'b0;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_HALT;
        endcase
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
`timescale 1ns/1ps
module tb_pc_seq_ctrl;

    localparam int W   = 15;
    localparam int IW  = 16;
    localparam int TMO = 8;

    logic          clk50m = 1'b0;
    logic          rst_n  = 1'b0;
    logic          run    = 1'b0;
    logic          step   = 1'b0;
    logic          instr_req;
    logic          instr_ack = 1'b0;
    logic [IW-1:0] instr_in  = '0;
    logic [IW-1:0] ir;
    logic          exec_valid;
    logic          alu_zr = 1'b0;
    logic          alu_ng = 1'b0;
    logic [W-1:0]  a_reg  = '0;
    logic          pc_en, pc_load, pc_inc;
    logic [W-1:0]  pc_cnt_in;
    logic          halted, fetch_err;

    pc_seq_ctrl #(.W(W), .IW(IW), .TMO(TMO)) dut (
        .clk50m(clk50m), .rst_n(rst_n), .run(run), .step(step),
        .instr_req(instr_req), .instr_ack(instr_ack), .instr_in(instr_in),
        .ir(ir), .exec_valid(exec_valid), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .a_reg(a_reg), .pc_en(pc_en), .pc_load(pc_load), .pc_inc(pc_inc),
        .pc_cnt_in(pc_cnt_in), .halted(halted), .fetch_err(fetch_err)
    );

    always #10 clk50m = ~clk50m;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // environment: program counter model, ROM, ack responder, event monitor
    logic [IW-1:0] rom [16];
    logic [W-1:0]  pc_model;
    logic [IW-1:0] cur_instr = '0;
    bit            use_rom   = 1'b1;
    int            ack_dly   = 1;
    int            rcnt      = 0;
    int            cyc       = 0;
    int            n_exec = 0, n_pcen = 0, n_load = 0, n_inc = 0, n_req = 0;
    int            exec_cyc[$];
    logic          exec_ld[$], exec_inc[$];
    logic [W-1:0]  exec_cnt[$];

    initial begin
        pc_model = '0;
        forever begin
            @(posedge clk50m or negedge rst_n);
            if (!rst_n)                pc_model <= '0;
            else if (pc_en && pc_load) pc_model <= pc_cnt_in;
            else if (pc_en && pc_inc)  pc_model <= pc_model + 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk50m);
            cyc++;
            if (!instr_req) begin
                rcnt      = 0;
                instr_ack = 1'b0;
            end else begin
                rcnt++;
                instr_ack = (rcnt - 1 == ack_dly);
            end
            instr_in = use_rom ? rom[pc_model[3:0]] : cur_instr;
            #1;
            if (instr_req) n_req++;
            if (pc_en)     n_pcen++;
            if (pc_load)   n_load++;
            if (pc_inc)    n_inc++;
            if (exec_valid) begin
                n_exec++;
                exec_cyc.push_back(cyc);
                exec_ld.push_back(pc_load);
                exec_inc.push_back(pc_inc);
                exec_cnt.push_back(pc_cnt_in);
            end
        end
    end

    task automatic tick();
        @(negedge clk50m);
        #2;
    endtask

    task automatic wait_halt(input int maxc);
        int n = 0;
        while (!halted && n < maxc) begin
            tick();
            n++;
        end
        chk("halt_wait", halted, 1);
    endtask

    task automatic do_step();
        tick(); step = 1'b1;
        tick(); step = 1'b0;
    endtask

    task automatic wait_execs(input int k, input int maxc);
        int n = 0;
        while (exec_cyc.size() < k && n < maxc) begin
            tick();
            n++;
        end
        chk("exec_wait", exec_cyc.size(), k);
    endtask

    task automatic clr_log();
        exec_cyc.delete(); exec_ld.delete(); exec_inc.delete(); exec_cnt.delete();
    endtask

    initial begin
        logic [2:0]    j;
        logic          exp;
        int            fcyc, nreq0;
        for (int i = 0; i < 16; i++) rom[i] = '0;

        // reset state
        repeat (3) tick();
        chk("rst_halted", halted, 1);
        chk("rst_ir", ir, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_req", instr_req, 0);
        chk("rst_pcen", pc_en, 0);
        chk("rst_exec", exec_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_halted", halted, 1);

        // two-instruction program, ack one cycle after req
        rom[0] = 16'h0005; rom[1] = 16'hE307; a_reg = 15'h0005;
        ack_dly = 1; clr_log();
        run = 1'b1;
        wait_execs(2, 50);
        run = 1'b0;
        wait_halt(20);
        chk("prog_n_exec", exec_cyc.size(), 2);
        chk("i1_inc", exec_inc[0], 1);
        chk("i1_ld", exec_ld[0], 0);
        chk("i2_ld", exec_ld[1], 1);
        chk("i2_inc", exec_inc[1], 0);
        chk("i2_cnt_in", exec_cnt[1], 15'h0005);
        chk("cpi3", exec_cyc[1] - exec_cyc[0], 3);
        chk("pc_jmp", pc_model, 15'h0005);
        chk("ir_jmp", ir, 16'hE307);

        // zero-wait ack: two cycles per instruction
        ack_dly = 0; clr_log();
        run = 1'b1;
        wait_execs(2, 50);
        run = 1'b0;
        wait_halt(20);
        chk("cpi2", exec_cyc[1] - exec_cyc[0], 2);
        chk("pc_zw", pc_model, 15'h0007);

        // jump decode sweep, one step per case
        use_rom = 1'b0; ack_dly = 1;
        for (int f = 0; f < 3; f++) begin
            alu_zr = (f == 0);
            alu_ng = (f == 1);
            for (int k = 1; k < 8; k++) begin
                j = 3'(k);
                cur_instr = 16'hE300 | 16'(k);
                exp = (j[2] & alu_ng) | (j[1] & alu_zr) | (j[0] & ~alu_zr & ~alu_ng);
                n_load = 0; n_inc = 0;
                do_step();
                wait_halt(20);
                chk($sformatf("jd_ld_%0d_%0h", f, k), n_load, {31'd0, exp});
                chk($sformatf("jd_inc_%0d_%0h", f, k), n_inc, {31'd0, ~exp});
            end
        end
        cur_instr = 16'h0007; alu_zr = 1'b0; alu_ng = 1'b0;
        n_load = 0; n_inc = 0;
        do_step();
        wait_halt(20);
        chk("a_instr_ld", n_load, 0);
        chk("a_instr_inc", n_inc, 1);

        // single step
        use_rom = 1'b1;
        n_exec = 0; n_pcen = 0;
        do_step();
        wait_halt(20);
        repeat (3) tick();
        chk("ss1_exec", n_exec, 1);
        chk("ss1_pcen", n_pcen, 1);
        chk("ss1_halted", halted, 1);
        do_step();
        wait_halt(20);
        repeat (3) tick();
        chk("ss2_exec", n_exec, 2);
        chk("ss2_pcen", n_pcen, 2);

        // fetch timeout
        ack_dly = 1000; n_pcen = 0; fcyc = -1;
        run = 1'b1;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (instr_req && fcyc < 0) fcyc = cyc;
            if (halted && fcyc >= 0) break;
        end
        run = 1'b0;
        chk("tmo_len", cyc - fcyc, TMO + 1);
        chk("tmo_err", fetch_err, 1);
        chk("tmo_halted", halted, 1);
        chk("tmo_pcen", n_pcen, 0);
        ack_dly = 1;
        do_step();
        chk("err_clr", fetch_err, 0);
        wait_halt(20);

        // run dropped during WAIT, late ack
        for (int i = 0; i < 16; i++) rom[i] = 16'h1234;
        ack_dly = 6; n_exec = 0;
        run = 1'b1;
        for (int n = 0; n < 10 && !instr_req; n++) tick();
        tick();
        run = 1'b0;
        wait_halt(40);
        chk("drop_exec", n_exec, 1);
        nreq0 = n_req;
        repeat (5) tick();
        chk("drop_noreq", n_req, nreq0);
        chk("drop_halted", halted, 1);
        chk("drop_ir", ir, 16'h1234);

        // async reset during WAIT
        ack_dly = 1000; n_pcen = 0;
        run = 1'b1;
        for (int n = 0; n < 10 && !instr_req; n++) tick();
        tick();
        chk("pre_rst_req", instr_req, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", instr_req, 0);
        chk("arst_halted", halted, 1);
        chk("arst_ir", ir, 0);
        chk("arst_pcen", pc_en, 0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("arst_no_pcen", n_pcen, 0);
        chk("arst_stay", halted, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
